// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit sequencer: FSM states, framing constants, source IDs.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        STROBE,
        WAIT_READY
    } seq_state_t;

    localparam logic [7:0] UART_SYNC_BYTE = 8'hA5;
    localparam logic [3:0] HDR_TAG        = 4'hC;

    localparam logic [1:0] SRC_SAMPLES = 2'd0;
    localparam logic [1:0] SRC_STATUS  = 2'd1;

    // Frame header carries the tag nibble and the sending source index.
    function automatic logic [7:0] make_header(input logic [1:0] src);
        return {HDR_TAG, 2'b00, src};
    endfunction

endpackage

// File: rtl/uart_tx_sequencer_rr_arbiter.sv
// Round-robin arbiter: picks the first asserted request at or after ptr, wrapping modulo NUM_SRC.
// Latency: purely combinational; the pointer register lives in the parent.
// Backpressure: none; the parent only acts on the grant when it is ready to accept a packet.
module rr_arbiter #(
    parameter int NUM_SRC = 2
) (
    input  logic [NUM_SRC-1:0] req,
    input  logic [1:0]         ptr,
    output logic [NUM_SRC-1:0] grant,
    output logic [1:0]         grant_idx,
    output logic               grant_vld
);

    // Scan sources starting at the pointer; the first hit wins and masks the rest.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        grant_vld = 1'b0;
        for (int k = 0; k < NUM_SRC; k++) begin
            for (int j = 0; j < NUM_SRC; j++) begin
                if (!grant_vld && req[j] && (j == ((int'(ptr) + k) % NUM_SRC))) begin
                    grant[j]  = 1'b1;
                    grant_idx = 2'(j);
                    grant_vld = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/uart_tx_sequencer.sv
// Arbitrates packet sources onto UART_TX and frames each packet as sync, header, payload (+ checksum with UART_TX_SEQ_CHECKSUM_EN).
// Latency: grant to first TX_en is 2 clk; each byte waits for TX_Ready to fall (accept) and rise again (done).
// Backpressure: sources hold req until grant_ack; TX_en is held until the synchronised TX_Ready drops.
module uart_tx_sequencer
    import uart_pkg::*;
#(
    parameter int         NUM_SRC   = 2,
    parameter int         PKT_BYTES = 2,
    parameter logic [7:0] SYNC_BYTE = UART_SYNC_BYTE
) (
    input  logic                           clk,
    input  logic                           reset_b,
    input  logic [NUM_SRC-1:0]             req,
    input  logic [NUM_SRC*PKT_BYTES*8-1:0] pkt_data,
    output logic [NUM_SRC-1:0]             grant_ack,
    input  logic                           TX_Ready,
    output logic                           TX_en,
    output logic [7:0]                     TX_Data_in,
    output logic                           busy,
    output logic [1:0]                     active_src,
    output logic [15:0]                    pkt_count
);

    localparam int PKT_W = PKT_BYTES * 8;
`ifdef UART_TX_SEQ_CHECKSUM_EN
    localparam int FRAME_LEN = 3 + PKT_BYTES;
`else
    localparam int FRAME_LEN = 2 + PKT_BYTES;
`endif
    localparam logic [3:0] LAST_IDX = 4'(FRAME_LEN - 1);

    seq_state_t         state;
    logic               rdy_meta;
    logic               rdy_s;
    logic [1:0]         ptr;
    logic [1:0]         nxt_ptr;
    logic [PKT_W-1:0]   pkt_buf;
    logic [PKT_W-1:0]   sel_pkt;
    logic [3:0]         byte_idx;
    logic [7:0]         frame_byte;
    logic [NUM_SRC-1:0] arb_grant;
    logic [1:0]         arb_idx;
    logic               arb_vld;

    rr_arbiter #(
        .NUM_SRC (NUM_SRC)
    ) u_arb (
        .req       (req),
        .ptr       (ptr),
        .grant     (arb_grant),
        .grant_idx (arb_idx),
        .grant_vld (arb_vld)
    );

    // Bring TX_Ready from the UART_clk-driven logic into clk through two flops.
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            rdy_meta <= 1'b0;
            rdy_s    <= 1'b0;
        end else begin
            rdy_meta <= TX_Ready;
            rdy_s    <= rdy_meta;
        end
    end

    // Route the granted source's payload to the capture buffer.
    always_comb begin
        sel_pkt = '0;
        for (int j = 0; j < NUM_SRC; j++) begin
            if (arb_grant[j]) begin
                sel_pkt = pkt_data[j*PKT_W +: PKT_W];
            end
        end
    end

    assign nxt_ptr = (arb_idx == 2'(NUM_SRC - 1)) ? 2'd0 : arb_idx + 2'd1;

`ifdef UART_TX_SEQ_CHECKSUM_EN
    logic [7:0] csum_byte;

    // Checksum covers the header and every payload byte; sync is excluded.
    always_comb begin
        csum_byte = make_header(active_src);
        for (int k = 0; k < PKT_BYTES; k++) begin
            csum_byte = csum_byte ^ pkt_buf[k*8 +: 8];
        end
    end
`endif

    // Select the frame byte for the current index: sync, header, payload MSB first, then checksum.
    always_comb begin
        frame_byte = SYNC_BYTE;
        if (byte_idx == 4'd1) begin
            frame_byte = make_header(active_src);
        end
        for (int k = 0; k < PKT_BYTES; k++) begin
            if (byte_idx == 4'(k + 2)) begin
                frame_byte = pkt_buf[(PKT_BYTES-1-k)*8 +: 8];
            end
        end
`ifdef UART_TX_SEQ_CHECKSUM_EN
        if (byte_idx == LAST_IDX) begin
            frame_byte = csum_byte;
        end
`endif
    end

    // Sequencer: grant and capture, then load / strobe / wait-ready once per frame byte.
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            state      <= IDLE;
            ptr        <= '0;
            pkt_buf    <= '0;
            byte_idx   <= '0;
            grant_ack  <= '0;
            busy       <= 1'b0;
            active_src <= '0;
            TX_en      <= 1'b0;
            TX_Data_in <= '0;
            pkt_count  <= '0;
        end else begin
            grant_ack <= '0;
            case (state)
                IDLE: begin
                    if (rdy_s && arb_vld) begin
                        pkt_buf    <= sel_pkt;
                        grant_ack  <= arb_grant;
                        busy       <= 1'b1;
                        active_src <= arb_idx;
                        ptr        <= nxt_ptr;
                        byte_idx   <= '0;
                        state      <= LOAD;
                    end
                end
                LOAD: begin
                    // Data settles a full clk ahead of the load strobe.
                    TX_Data_in <= frame_byte;
                    state      <= STROBE;
                end
                STROBE: begin
                    if (!TX_en) begin
                        TX_en <= 1'b1;
                    end else if (!rdy_s) begin
                        TX_en <= 1'b0;
                        state <= WAIT_READY;
                    end
                end
                WAIT_READY: begin
                    if (rdy_s) begin
                        if (byte_idx == LAST_IDX) begin
                            pkt_count <= pkt_count + 16'd1;
                            busy      <= 1'b0;
                            state     <= IDLE;
                        end else begin
                            byte_idx <= byte_idx + 4'd1;
                            state    <= LOAD;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_sequencer.sv
// Bench for uart_tx_sequencer: behavioural UART_TX model plus a frame/arbitration reference model.
// Latency: n/a.
// Backpressure: the UART_TX model holds TX_Ready low for a programmable accept delay and busy time.
module tb_uart_tx_sequencer;

    localparam int NS = 2;
    localparam int PB = 2;

    logic             clk      = 1'b0;
    logic             reset_b  = 1'b0;
    logic [NS-1:0]    req      = '0;
    logic [NS*PB*8-1:0] pkt_data = '0;
    logic [NS-1:0]    grant_ack;
    logic             TX_Ready = 1'b1;
    logic             TX_en;
    logic [7:0]       TX_Data_in;
    logic             busy;
    logic [1:0]       active_src;
    logic [15:0]      pkt_count;

    uart_tx_sequencer #(
        .NUM_SRC   (NS),
        .PKT_BYTES (PB),
        .SYNC_BYTE (8'hA5)
    ) dut (
        .clk        (clk),
        .reset_b    (reset_b),
        .req        (req),
        .pkt_data   (pkt_data),
        .grant_ack  (grant_ack),
        .TX_Ready   (TX_Ready),
        .TX_en      (TX_en),
        .TX_Data_in (TX_Data_in),
        .busy       (busy),
        .active_src (active_src),
        .pkt_count  (pkt_count)
    );

    always #5 clk = ~clk;

    // ---------------- UART_TX behavioural model ----------------
    int         fall_dly  = 3;
    int         busy_clks = 20;
    bit         mdl_hold  = 1'b0;
    int         mdl_st    = 0;
    int         mdl_cnt   = 0;
    int         en_run    = 0;
    int         dat_bad   = 0;
    logic [7:0] last_dat  = '0;
    logic [7:0] cap_q[$];
    int         en_len_q[$];

    always @(negedge clk) begin
        case (mdl_st)
            0: begin
                TX_Ready = !mdl_hold;
                if (!mdl_hold && TX_en) begin
                    cap_q.push_back(TX_Data_in);
                    last_dat = TX_Data_in;
                    mdl_cnt  = fall_dly;
                    mdl_st   = 1;
                end
            end
            1: begin
                mdl_cnt--;
                if (mdl_cnt <= 0) begin
                    TX_Ready = 1'b0;
                    mdl_cnt  = busy_clks;
                    mdl_st   = 2;
                end
            end
            default: begin
                mdl_cnt--;
                if (mdl_cnt <= 0) begin
                    TX_Ready = 1'b1;
                    mdl_st   = 0;
                end
            end
        endcase
        if (TX_en) begin
            en_run++;
            if (TX_Data_in !== last_dat) dat_bad++;
        end else if (en_run > 0) begin
            en_len_q.push_back(en_run);
            en_run = 0;
        end
    end

    // ---------------- reference model and checking ----------------
    int          n_chk  = 0;
    int          n_pass = 0;
    int          m_ptr  = 0;
    logic [15:0] exp_cnt = '0;
    logic [7:0]  exp_q[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    // Expected winner: first requesting source at or after the pointer, wrapping.
    function automatic int arb(input logic [NS-1:0] m, input int p);
        logic [NS-1:0] t;
        for (int k = 0; k < NS; k++) begin
            t = m >> ((p + k) % NS);
            if (t[0]) return (p + k) % NS;
        end
        return -1;
    endfunction

    function automatic void add_frame(input int src, input logic [15:0] p);
        logic [7:0] hdr;
        hdr = {4'hC, 2'b00, src[1:0]};
        exp_q.push_back(8'hA5);
        exp_q.push_back(hdr);
        exp_q.push_back(p[15:8]);
        exp_q.push_back(p[7:0]);
`ifdef UART_TX_SEQ_CHECKSUM_EN
        exp_q.push_back(hdr ^ p[15:8] ^ p[7:0]);
`endif
    endfunction

    function automatic logic [15:0] payload_of(input int s);
        logic [NS*PB*8-1:0] t;
        t = pkt_data >> (s * 16);
        return t[15:0];
    endfunction

    task automatic set_pl(input int s, input logic [15:0] v);
        if (s == 0) pkt_data[15:0] = v;
        else pkt_data[31:16] = v;
    endtask

    task automatic run_grant(input int s, input logic [NS-1:0] clr, input string tag);
        int t;
        logic [NS-1:0] oh;
        t  = 0;
        oh = {{(NS-1){1'b0}}, 1'b1} << s;
        while (grant_ack == '0 && t < 3000) begin
            @(negedge clk);
            t++;
        end
        chk({tag, "_ack"}, 32'(grant_ack), 32'(oh));
        req   = req & ~clr;
        m_ptr = (s + 1) % NS;
        if (grant_ack != '0) begin
            chk({tag, "_src"}, 32'(active_src), s);
            chk({tag, "_busy"}, 32'(busy), 1);
            @(negedge clk);
            chk({tag, "_pulse"}, 32'(grant_ack), 0);
            chk({tag, "_lead"}, 32'(TX_en), 0);
            chk({tag, "_lead_dat"}, 32'(TX_Data_in), 32'h A5);
            @(negedge clk);
            chk({tag, "_lat"}, 32'(TX_en), 1);
        end
    endtask

    task automatic wait_done(input string tag);
        int t;
        t = 0;
        while (busy && t < 5000) begin
            @(negedge clk);
            t++;
        end
        chk({tag, "_done"}, 32'(busy), 0);
        exp_cnt = exp_cnt + 16'd1;
        chk({tag, "_cnt"}, 32'(pkt_count), 32'(exp_cnt));
    endtask

    task automatic check_frame(input int base, input string tag);
        chk({tag, "_len"}, cap_q.size() - base, exp_q.size());
        for (int k = 0; k < exp_q.size(); k++) begin
            if (base + k < cap_q.size()) chk({tag, "_byte"}, 32'(cap_q[base + k]), 32'(exp_q[k]));
        end
        exp_q.delete();
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        reset_b = 1'b0;
        @(negedge clk);
        reset_b = 1'b1;
        m_ptr   = 0;
        exp_cnt = '0;
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int  base;
        int  ebase;
        int  s;
        int  bad0;
        bit  any;
        logic [NS-1:0] nb;

        // Reset state with the transmitter reporting not-ready.
        mdl_hold = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_tx_en", 32'(TX_en), 0);
        chk("rst_tx_dat", 32'(TX_Data_in), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_grant", 32'(grant_ack), 0);
        chk("rst_src", 32'(active_src), 0);
        chk("rst_cnt", 32'(pkt_count), 0);
        reset_b = 1'b1;

        // No grant while TX_Ready is low, then the single-request frame.
        set_pl(0, 16'h4146);
        req = 2'b01;
        any = 1'b0;
        repeat (15) begin
            @(negedge clk);
            if (grant_ack != '0) any = 1'b1;
        end
        chk("rdy_low_no_grant", 32'(any), 0);
        chk("rdy_low_busy", 32'(busy), 0);
        mdl_hold = 1'b0;
        base = cap_q.size();
        s = arb(req, m_ptr);
        add_frame(s, payload_of(s));
        run_grant(s, 2'b01, "single");
        wait_done("single");
        check_frame(base, "single");

        // Contention from reset: strict rotation with both requests held.
        pulse_reset();
        set_pl(0, 16'h1111);
        set_pl(1, 16'h2222);
        base = cap_q.size();
        req = 2'b11;
        for (int i = 0; i < 4; i++) begin
            s = arb(req, m_ptr);
            add_frame(s, payload_of(s));
            run_grant(s, (i == 3) ? 2'b11 : 2'b00, "contend");
            wait_done("contend");
        end
        chk("contend_total", 32'(pkt_count), 4);
        check_frame(base, "contend");

        // Slow accept: TX_en must be held, data steady, no duplicate bytes.
        fall_dly = 10;
        set_pl(1, 16'($urandom()));
        base  = cap_q.size();
        ebase = en_len_q.size();
        bad0  = dat_bad;
        req = 2'b10;
        s = arb(req, m_ptr);
        add_frame(s, payload_of(s));
        run_grant(s, 2'b10, "hold");
        wait_done("hold");
        check_frame(base, "hold");
        chk("hold_dat_stable", dat_bad - bad0, 0);
        for (int k = ebase; k < en_len_q.size(); k++) begin
            chk("hold_en_len", 32'(en_len_q[k] >= 10), 1);
        end
        fall_dly = 3;

        // Request present for exactly the granting clock still yields a full frame.
        set_pl(0, 16'($urandom()));
        base = cap_q.size();
        req = 2'b01;
        s = arb(req, m_ptr);
        add_frame(s, payload_of(s));
        @(negedge clk);
        req = 2'b00;
        run_grant(s, 2'b00, "drop");
        wait_done("drop");
        check_frame(base, "drop");

        // Randomised traffic: level requests accumulate, winners drop their request.
        for (int it = 0; it < 10; it++) begin
            busy_clks = $urandom_range(4, 24);
            fall_dly  = $urandom_range(1, 6);
            nb = NS'($urandom_range(0, (1 << NS) - 1));
            if ((req | nb) == '0) nb = {{(NS-1){1'b0}}, 1'b1} << $urandom_range(0, NS - 1);
            for (int j = 0; j < NS; j++) begin
                if (nb[j] && !req[j]) set_pl(j, 16'($urandom()));
            end
            req  = req | nb;
            base = cap_q.size();
            s = arb(req, m_ptr);
            add_frame(s, payload_of(s));
            run_grant(s, {{(NS-1){1'b0}}, 1'b1} << s, "rand");
            wait_done("rand");
            check_frame(base, "rand");
        end
        req = '0;
        busy_clks = 20;
        fall_dly  = 3;

        // Reset in the middle of a payload byte, then a fresh frame from source 1.
        set_pl(0, 16'h4146);
        base = cap_q.size();
        req = 2'b01;
        s = arb(req, m_ptr);
        run_grant(s, 2'b01, "mid");
        begin
            int t;
            t = 0;
            while (cap_q.size() < base + 3 && t < 3000) begin
                @(negedge clk);
                t++;
            end
        end
        @(negedge clk);
        chk("mid_pre_en", 32'(TX_en), 1);
        reset_b = 1'b0;
        #1;
        chk("mid_rst_en", 32'(TX_en), 0);
        chk("mid_rst_busy", 32'(busy), 0);
        chk("mid_rst_grant", 32'(grant_ack), 0);
        @(negedge clk);
        @(negedge clk);
        reset_b = 1'b1;
        m_ptr   = 0;
        exp_cnt = '0;
        base = cap_q.size();
        set_pl(1, 16'h5A3C);
        req = 2'b10;
        s = arb(req, m_ptr);
        add_frame(s, payload_of(s));
        run_grant(s, 2'b10, "after_rst");
        wait_done("after_rst");
        check_frame(base, "after_rst");

        // Frame counter wraps from all-ones to zero.
        @(negedge clk);
        force dut.pkt_count = 16'hFFFF;
        @(negedge clk);
        release dut.pkt_count;
        exp_cnt = 16'hFFFF;
        set_pl(0, 16'($urandom()));
        base = cap_q.size();
        req = 2'b01;
        s = arb(req, m_ptr);
        add_frame(s, payload_of(s));
        run_grant(s, 2'b01, "wrap");
        wait_done("wrap");
        check_frame(base, "wrap");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
